calc_seq_ctrl: RTL and testbench
================================

Name: calc_seq_ctrl

Overview:
- Keypad-driven sequencer for the BCD calculator ALU.
- Assembles operand A, the operator, and operand B from single-key events, then drives the ALU inputs and waits a fixed latency.
- Captures the ALU result and sign, flags addition overflow, and presents the value for the display.
- Sits between the keypad decoder and the ALU/display mux; the ALU itself is unchanged.

Parameters:
- ALU_LAT, 3, clock cycles from the last ALU input change to a valid ALU result (covers the registered multipliers inside the ALU).
- NDIG, 4, BCD digits per operand (fixed at 4; widths below assume 4).

Ports:
- clk  in  1  system clock
- clear  in  1  asynchronous active-high reset
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  4  0-9 digit, 4'hA add, 4'hB subtract, 4'hE equals, 4'hC clear-all; other codes ignored
- alu_result  in  16  ALU BCD result (magnitude)
- alu_neg  in  1  ALU sign flag (1 = B greater than A on subtract)
- bcd1  out  16  ALU operand A (BCD)
- bcd2  out  16  ALU operand B (BCD)
- op_selected  out  2  ALU opcode: 01 add, 10 subtract, 00 idle
- disp_bcd  out  16  value to display
- disp_neg  out  1  display minus sign
- disp_ovf  out  1  addition overflow flag
- busy  out  1  high while waiting for the ALU
- res_valid  out  1  one-cycle pulse when the result is captured

Behaviour:
- Reset (async, clear=1): state=ENTER_A; bcd1, bcd2, disp_bcd = 16'h0; op_selected=00; disp_neg, disp_ovf, busy, res_valid = 0; digit counter = 0; wait counter = 0.
- All outputs are registered. Keys are sampled only on clk edges where key_valid=1.
- ENTER_A state:
  - Digit key: bcd1 <= {bcd1[11:0], key}, digit counter +1. With 4 digits already held, further digits are ignored.
  - Display shows bcd1; disp_neg and disp_ovf are held at 0.
  - Add/Sub key: latch the opcode internally, clear the digit counter, go to ENTER_B. Display keeps bcd1. op_selected stays 00 until compute.
  - Equals key: ignored.
- ENTER_B state:
  - Digit key: shifts into bcd2 the same way, with the same 4-digit limit. Display shows bcd2.
  - Add/Sub key: replaces the latched opcode; bcd2 is unchanged.
  - Equals key: drive op_selected with the latched opcode, busy <= 1, load wait counter = ALU_LAT, go to WAIT.
- WAIT state:
  - Every key except clear-all is ignored.
  - bcd1, bcd2 and op_selected are held stable.
  - Wait counter decrements each cycle. On the cycle it reaches 0:
    - disp_bcd <= alu_result, disp_neg <= alu_neg.
    - disp_ovf <= (opcode == add) && (alu_result < bcd1), using a BCD digit-wise magnitude compare.
    - res_valid pulses for 1 cycle, busy <= 0, go to SHOW.
  - Total latency from the equals key to res_valid is ALU_LAT+1 cycles.
- SHOW state:
  - op_selected returns to 00. The result stays on the display.
  - Digit key: start a new calculation. bcd1 <= {12'h0, key}, bcd2 <= 0, counter = 1, flags cleared, go to ENTER_A.
  - Add/Sub key with disp_neg=0 and disp_ovf=0 (chaining): bcd1 <= disp_bcd, bcd2 <= 0, latch the opcode, counter = 0, go to ENTER_B.
  - Add/Sub key with disp_neg=1 or disp_ovf=1: ignored.
  - Equals key: repeat the last operation. bcd1 <= disp_bcd, with the same legality rule as chaining (ignored if negative or overflowed); bcd2 is kept; enter WAIT.
- Clear-all key (any state, including WAIT): synchronous return to the reset values on the next edge. An in-flight ALU wait is abandoned, with no res_valid.
- A key_valid coincident with the wait counter reaching 0 is ignored, unless it is clear-all; clear-all wins over the capture.
- Asserting clear mid-operation returns to the reset state immediately; no partial result is displayed.

Decomposition:
- Shared package calc_pkg:
  - key code constants: KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_EQ=4'hE, KEY_CLR=4'hC.
  - ALU opcode constants: OP_NONE=2'b00, OP_ADD=2'b01, OP_SUB=2'b10.
  - state encoding: ENTER_A, ENTER_B, WAIT, SHOW.
- One sub-module: bcd_cmp4 (combinational 4-digit BCD less-than), used for overflow detection.

Test Plan:
- Keys 1,2,3,A,4,5,E with alu_result=16'h0168, alu_neg=0 -> op_selected=01 with bcd1=16'h0123, bcd2=16'h0045 until the end of WAIT; res_valid exactly 4 cycles after E; disp_bcd=16'h0168, disp_ovf=0.
- Keys 2,0,B,5,0,E with alu_result=16'h0030, alu_neg=1 -> op_selected=10; disp_bcd=16'h0030, disp_neg=1; a following A key is ignored (state stays SHOW).
- Keys 9,9,9,9,9 -> bcd1=16'h9999 (5th digit dropped). Then A,9,9,9,9,E with alu_result=16'h9998 -> disp_ovf=1.
- Chaining: after result 16'h0168, keys A,2,E -> bcd1=16'h0168, bcd2=16'h0002, op_selected=01.
- Clear-all key during WAIT -> next cycle all outputs are at reset values, no res_valid pulse; digit keys pressed during WAIT are ignored.
- Assert clear asynchronously (between clk edges) in ENTER_B -> outputs reset immediately; after release, key 7 gives bcd1=16'h0007.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants and types for the BCD calculator keypad sequencer.
//   - Keypad codes for the operator, equals and clear-all keys.
//   - ALU opcodes driven on op_selected.
//   - Sequencer state encoding.
//   - Small key classification helpers.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hC;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  typedef enum logic [1:0] {
    ENTER_A,
    ENTER_B,
    WAIT,
    SHOW
  } calc_state_e;

  function automatic logic is_digit(logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op_key(logic [3:0] k);
    return (k == KEY_ADD) || (k == KEY_SUB);
  endfunction

  function automatic logic [1:0] key_to_op(logic [3:0] k);
    return (k == KEY_SUB) ? OP_SUB : OP_ADD;
  endfunction

endpackage

// File: rtl/bcd_cmp4.sv
// Combinational 4-digit BCD magnitude compare.
// Ports:
//   a_i  - 4-digit BCD value A
//   b_i  - 4-digit BCD value B
//   lt_o - high when A < B
module bcd_cmp4 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        lt_o
);

  // Walk digits from least to most significant; a differing higher digit
  // overrides any decision made by the lower ones.
  always_comb begin
    lt_o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (a_i[4*i +: 4] != b_i[4*i +: 4]) begin
        lt_o = (a_i[4*i +: 4] < b_i[4*i +: 4]);
      end
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad-driven sequencer for the BCD calculator ALU. Builds operand A, the
// operator and operand B from single key events, drives the ALU, waits a fixed
// latency, then captures result, sign and addition overflow for the display.
// Ports:
//   clk, clear           - clock, asynchronous active-high reset
//   key_valid, key_code  - one-cycle key strobe and code
//   alu_result, alu_neg  - ALU BCD magnitude and sign
//   bcd1, bcd2           - ALU operands A and B
//   op_selected          - ALU opcode (00 idle, 01 add, 10 subtract)
//   disp_bcd/neg/ovf     - display value, minus sign, overflow flag
//   busy                 - waiting for the ALU
//   res_valid            - one-cycle pulse on result capture
module calc_seq_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned ALU_LAT = 3,
  parameter int unsigned NDIG    = 4
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] alu_result,
  input  logic        alu_neg,
  output logic [15:0] bcd1,
  output logic [15:0] bcd2,
  output logic [1:0]  op_selected,
  output logic [15:0] disp_bcd,
  output logic        disp_neg,
  output logic        disp_ovf,
  output logic        busy,
  output logic        res_valid
);

  localparam int unsigned WaitW  = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam logic [2:0]  MaxDig = 3'(NDIG);

  calc_state_e      state_q, state_d;
  logic [15:0]      bcd1_q, bcd1_d;
  logic [15:0]      bcd2_q, bcd2_d;
  logic [1:0]       op_q, op_d;          // latched operator
  logic [1:0]       op_sel_q, op_sel_d;  // opcode presented to the ALU
  logic [15:0]      disp_bcd_q, disp_bcd_d;
  logic             disp_neg_q, disp_neg_d;
  logic             disp_ovf_q, disp_ovf_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [2:0]       dig_cnt_q, dig_cnt_d;
  logic [WaitW-1:0] wait_q, wait_d;

  logic key_digit, key_op, key_eq, key_clr;
  logic res_lt_a;
  logic show_legal;

  assign key_digit  = key_valid && is_digit(key_code);
  assign key_op     = key_valid && is_op_key(key_code);
  assign key_eq     = key_valid && (key_code == KEY_EQ);
  assign key_clr    = key_valid && (key_code == KEY_CLR);
  // Chaining/repeat only makes sense from a non-negative, non-overflowed result.
  assign show_legal = !disp_neg_q && !disp_ovf_q;

  // An unsigned add that wrapped past 9999 yields a result smaller than A.
  bcd_cmp4 u_ovf_cmp (
    .a_i  (alu_result),
    .b_i  (bcd1_q),
    .lt_o (res_lt_a)
  );

  always_comb begin
    state_d     = state_q;
    bcd1_d      = bcd1_q;
    bcd2_d      = bcd2_q;
    op_d        = op_q;
    op_sel_d    = op_sel_q;
    disp_bcd_d  = disp_bcd_q;
    disp_neg_d  = disp_neg_q;
    disp_ovf_d  = disp_ovf_q;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    dig_cnt_d   = dig_cnt_q;
    wait_d      = wait_q;

    if (key_clr) begin
      // Clear-all beats everything, including a capture in the same cycle.
      state_d    = ENTER_A;
      bcd1_d     = 16'h0;
      bcd2_d     = 16'h0;
      op_d       = OP_NONE;
      op_sel_d   = OP_NONE;
      disp_bcd_d = 16'h0;
      disp_neg_d = 1'b0;
      disp_ovf_d = 1'b0;
      busy_d     = 1'b0;
      dig_cnt_d  = 3'd0;
      wait_d     = '0;
    end else begin
      unique case (state_q)
        ENTER_A: begin
          disp_neg_d = 1'b0;
          disp_ovf_d = 1'b0;
          if (key_digit) begin
            if (dig_cnt_q < MaxDig) begin
              bcd1_d     = {bcd1_q[11:0], key_code};
              disp_bcd_d = {bcd1_q[11:0], key_code};
              dig_cnt_d  = dig_cnt_q + 3'd1;
            end
          end else if (key_op) begin
            op_d      = key_to_op(key_code);
            dig_cnt_d = 3'd0;
            state_d   = ENTER_B;
          end
        end

        ENTER_B: begin
          if (key_digit) begin
            if (dig_cnt_q < MaxDig) begin
              bcd2_d     = {bcd2_q[11:0], key_code};
              disp_bcd_d = {bcd2_q[11:0], key_code};
              dig_cnt_d  = dig_cnt_q + 3'd1;
            end
          end else if (key_op) begin
            op_d = key_to_op(key_code);
          end else if (key_eq) begin
            op_sel_d = op_q;
            busy_d   = 1'b1;
            wait_d   = WaitW'(ALU_LAT);
            state_d  = WAIT;
          end
        end

        WAIT: begin
          // Counter hits zero ALU_LAT edges after the inputs changed; the
          // result is sampled one edge later.
          if (wait_q == '0) begin
            disp_bcd_d  = alu_result;
            disp_neg_d  = alu_neg;
            disp_ovf_d  = (op_q == OP_ADD) && res_lt_a;
            res_valid_d = 1'b1;
            busy_d      = 1'b0;
            op_sel_d    = OP_NONE;
            state_d     = SHOW;
          end else begin
            wait_d = wait_q - WaitW'(1);
          end
        end

        SHOW: begin
          if (key_digit) begin
            bcd1_d     = {12'h0, key_code};
            bcd2_d     = 16'h0;
            disp_bcd_d = {12'h0, key_code};
            disp_neg_d = 1'b0;
            disp_ovf_d = 1'b0;
            dig_cnt_d  = 3'd1;
            state_d    = ENTER_A;
          end else if (key_op && show_legal) begin
            bcd1_d    = disp_bcd_q;
            bcd2_d    = 16'h0;
            op_d      = key_to_op(key_code);
            dig_cnt_d = 3'd0;
            state_d   = ENTER_B;
          end else if (key_eq && show_legal) begin
            // Repeat: previous result becomes A, B and operator are reused.
            bcd1_d   = disp_bcd_q;
            op_sel_d = op_q;
            busy_d   = 1'b1;
            wait_d   = WaitW'(ALU_LAT);
            state_d  = WAIT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q     <= ENTER_A;
      bcd1_q      <= 16'h0;
      bcd2_q      <= 16'h0;
      op_q        <= OP_NONE;
      op_sel_q    <= OP_NONE;
      disp_bcd_q  <= 16'h0;
      disp_neg_q  <= 1'b0;
      disp_ovf_q  <= 1'b0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      dig_cnt_q   <= 3'd0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      bcd1_q      <= bcd1_d;
      bcd2_q      <= bcd2_d;
      op_q        <= op_d;
      op_sel_q    <= op_sel_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_neg_q  <= disp_neg_d;
      disp_ovf_q  <= disp_ovf_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      dig_cnt_q   <= dig_cnt_d;
      wait_q      <= wait_d;
    end
  end

  assign bcd1        = bcd1_q;
  assign bcd2        = bcd2_q;
  assign op_selected = op_sel_q;
  assign disp_bcd    = disp_bcd_q;
  assign disp_neg    = disp_neg_q;
  assign disp_ovf    = disp_ovf_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Bench for calc_seq_ctrl: directed scenarios plus a random key stream
// checked against a decimal-arithmetic model of the calculator.
module tb_calc_seq_ctrl;

  localparam int unsigned LAT = 3;
  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_EQ  = 4'hE;
  localparam logic [3:0] K_CLR = 4'hC;

  logic        clk = 1'b0;
  logic        clear;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] alu_result;
  logic        alu_neg;
  logic [15:0] bcd1, bcd2, disp_bcd;
  logic [1:0]  op_selected;
  logic        disp_neg, disp_ovf, busy, res_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  calc_seq_ctrl #(
    .ALU_LAT (LAT),
    .NDIG    (4)
  ) dut (
    .clk         (clk),
    .clear       (clear),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .alu_result  (alu_result),
    .alu_neg     (alu_neg),
    .bcd1        (bcd1),
    .bcd2        (bcd2),
    .op_selected (op_selected),
    .disp_bcd    (disp_bcd),
    .disp_neg    (disp_neg),
    .disp_ovf    (disp_ovf),
    .busy        (busy),
    .res_valid   (res_valid)
  );

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic press_seq(input logic [3:0] ks[$]);
    foreach (ks[i]) press(ks[i]);
  endtask

  task automatic run_wait(output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (res_valid) break;
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; key_valid = 1'b0; key_code = 4'h0; alu_result = 16'h0; alu_neg = 1'b0;
    #12;
    total++;
    if ({bcd1, bcd2, disp_bcd} !== 48'h0) begin
      bad++; $display("FAIL reset_values: got %h %h %h want 0", bcd1, bcd2, disp_bcd);
    end
    total++;
    if ({op_selected, disp_neg, disp_ovf, busy, res_valid} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000",
                      {op_selected, disp_neg, disp_ovf, busy, res_valid});
    end
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_add();
    int cyc;
    logic stable;
    press_seq('{4'h1, 4'h2, 4'h3});
    total++;
    if (bcd1 !== 16'h0123 || disp_bcd !== 16'h0123) begin
      bad++; $display("FAIL add_enter_a: got bcd1=%h disp=%h want 0123", bcd1, disp_bcd);
    end
    press_seq('{K_ADD, 4'h4, 4'h5});
    total++;
    if (bcd2 !== 16'h0045 || disp_bcd !== 16'h0045 || op_selected !== 2'b00) begin
      bad++; $display("FAIL add_enter_b: got bcd2=%h disp=%h op=%b want 0045 0045 00",
                      bcd2, disp_bcd, op_selected);
    end
    alu_result = 16'h0168; alu_neg = 1'b0;
    press(K_EQ);
    stable = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      if (op_selected !== 2'b01 || bcd1 !== 16'h0123 || bcd2 !== 16'h0045 || busy !== 1'b1)
        stable = 1'b0;
      @(negedge clk);
      cyc++;
      if (res_valid) break;
    end
    total++;
    if (!stable) begin
      bad++; $display("FAIL add_wait_stable: got op/bcd change during wait want held 01/0123/0045");
    end
    total++;
    if (cyc != LAT + 1) begin
      bad++; $display("FAIL add_latency: got %0d want %0d", cyc, LAT + 1);
    end
    total++;
    if (disp_bcd !== 16'h0168 || disp_ovf !== 1'b0 || disp_neg !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL add_result: got %h ovf=%b neg=%b busy=%b want 0168 0 0 0",
                      disp_bcd, disp_ovf, disp_neg, busy);
    end
    @(negedge clk);
    total++;
    if (res_valid !== 1'b0 || op_selected !== 2'b00) begin
      bad++; $display("FAIL add_pulse: got res_valid=%b op=%b want 0 00", res_valid, op_selected);
    end
  endtask

  task automatic test_chain();
    int cyc;
    press(K_ADD);
    total++;
    if (bcd1 !== 16'h0168 || bcd2 !== 16'h0000) begin
      bad++; $display("FAIL chain_load: got bcd1=%h bcd2=%h want 0168 0000", bcd1, bcd2);
    end
    press(4'h2);
    alu_result = 16'h0170;
    press(K_EQ);
    total++;
    if (bcd1 !== 16'h0168 || bcd2 !== 16'h0002 || op_selected !== 2'b01) begin
      bad++; $display("FAIL chain_compute: got %h %h op=%b want 0168 0002 01",
                      bcd1, bcd2, op_selected);
    end
    run_wait(cyc);
    total++;
    if (cyc != LAT + 1 || disp_bcd !== 16'h0170) begin
      bad++; $display("FAIL chain_result: got cyc=%0d disp=%h want %0d 0170", cyc, disp_bcd, LAT + 1);
    end
  endtask

  task automatic test_sub_neg();
    int cyc;
    press_seq('{K_CLR, 4'h2, 4'h0, K_SUB, 4'h5, 4'h0});
    alu_result = 16'h0030; alu_neg = 1'b1;
    press(K_EQ);
    total++;
    if (op_selected !== 2'b10) begin
      bad++; $display("FAIL sub_op: got %b want 10", op_selected);
    end
    run_wait(cyc);
    total++;
    if (disp_bcd !== 16'h0030 || disp_neg !== 1'b1) begin
      bad++; $display("FAIL sub_result: got %h neg=%b want 0030 1", disp_bcd, disp_neg);
    end
    press(K_ADD);
    press(K_EQ);
    total++;
    if (bcd1 !== 16'h0020 || bcd2 !== 16'h0050 || disp_bcd !== 16'h0030 || busy !== 1'b0) begin
      bad++; $display("FAIL sub_chain_ignored: got %h %h %h busy=%b want 0020 0050 0030 0",
                      bcd1, bcd2, disp_bcd, busy);
    end
    press(4'h3);
    total++;
    if (bcd1 !== 16'h0003 || bcd2 !== 16'h0000 || disp_neg !== 1'b0) begin
      bad++; $display("FAIL sub_new_calc: got %h %h neg=%b want 0003 0000 0", bcd1, bcd2, disp_neg);
    end
  endtask

  task automatic test_digit_limit_ovf();
    int cyc;
    press_seq('{K_CLR, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9});
    total++;
    if (bcd1 !== 16'h9999) begin
      bad++; $display("FAIL digit_limit: got %h want 9999", bcd1);
    end
    press_seq('{K_ADD, 4'h9, 4'h9, 4'h9, 4'h9, 4'h1});
    total++;
    if (bcd2 !== 16'h9999) begin
      bad++; $display("FAIL digit_limit_b: got %h want 9999", bcd2);
    end
    alu_result = 16'h9998; alu_neg = 1'b0;
    press(K_EQ);
    run_wait(cyc);
    total++;
    if (disp_ovf !== 1'b1 || disp_bcd !== 16'h9998) begin
      bad++; $display("FAIL add_ovf: got ovf=%b disp=%h want 1 9998", disp_ovf, disp_bcd);
    end
    press(K_SUB);
    total++;
    if (bcd1 !== 16'h9999 || bcd2 !== 16'h9999) begin
      bad++; $display("FAIL ovf_chain_ignored: got %h %h want 9999 9999", bcd1, bcd2);
    end
  endtask

  task automatic test_clr_in_wait();
    logic seen;
    press_seq('{K_CLR, 4'h1, K_ADD, 4'h2});
    alu_result = 16'h0003; alu_neg = 1'b0;
    press(K_EQ);
    press(4'h7);
    total++;
    if (bcd1 !== 16'h0001 || bcd2 !== 16'h0002 || busy !== 1'b1) begin
      bad++; $display("FAIL wait_digit_ignored: got %h %h busy=%b want 0001 0002 1", bcd1, bcd2, busy);
    end
    // This clear-all lands on the same edge the capture would happen.
    press(K_CLR);
    seen = res_valid;
    total++;
    if ({bcd1, bcd2, disp_bcd, op_selected, disp_neg, disp_ovf, busy} !== 53'h0) begin
      bad++; $display("FAIL wait_clear: got %h %h %h op=%b flags=%b want all 0", bcd1, bcd2,
                      disp_bcd, op_selected, {disp_neg, disp_ovf, busy});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | res_valid;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL wait_clear_no_pulse: got res_valid=1 want 0");
    end
  endtask

  task automatic test_async_clear();
    press_seq('{K_CLR, 4'h1, K_ADD, 4'h3});
    #2 clear = 1'b1;
    #1;
    total++;
    if ({bcd1, bcd2, disp_bcd} !== 48'h0) begin
      bad++; $display("FAIL async_clear: got %h %h %h want 0", bcd1, bcd2, disp_bcd);
    end
    @(negedge clk);
    clear = 1'b0;
    press(4'h7);
    total++;
    if (bcd1 !== 16'h0007 || disp_bcd !== 16'h0007) begin
      bad++; $display("FAIL async_after: got %h %h want 0007 0007", bcd1, disp_bcd);
    end
  endtask

  // Model: ph 0 = typing A, 1 = typing B, 2 = showing a result.
  task automatic test_random(input int n);
    int ph, a, b, nd, op, disp, res, cyc, r;
    bit dneg, dovf, rneg, go, stable;
    logic [3:0] k;
    logic [1:0] eop;
    logic [52:0] exp_v, got_v;
    press(K_CLR);
    ph = 0; a = 0; b = 0; nd = 0; op = 0; disp = 0; dneg = 0; dovf = 0;
    for (int it = 0; it < n; it++) begin
      r = $urandom_range(0, 31);
      if (r < 18)      k = 4'($urandom_range(0, 9));
      else if (r < 21) k = K_ADD;
      else if (r < 24) k = K_SUB;
      else if (r < 29) k = K_EQ;
      else if (r == 29) k = K_CLR;
      else             k = (r == 30) ? 4'hD : 4'hF;
      go = 0;
      if (k <= 4'd9) begin
        if (ph == 0) begin
          if (nd < 4) begin a = a * 10 + int'(k); nd++; disp = a; end
        end else if (ph == 1) begin
          if (nd < 4) begin b = b * 10 + int'(k); nd++; disp = b; end
        end else begin
          a = int'(k); b = 0; nd = 1; disp = a; dneg = 0; dovf = 0; ph = 0;
        end
      end else if (k == K_ADD || k == K_SUB) begin
        if (ph == 0) begin
          op = (k == K_ADD) ? 1 : 2; nd = 0; ph = 1;
        end else if (ph == 1) begin
          op = (k == K_ADD) ? 1 : 2;
        end else if (!dneg && !dovf) begin
          a = disp; b = 0; op = (k == K_ADD) ? 1 : 2; nd = 0; ph = 1;
        end
      end else if (k == K_EQ) begin
        if (ph == 1) go = 1;
        else if (ph == 2 && !dneg && !dovf) begin a = disp; go = 1; end
      end else if (k == K_CLR) begin
        ph = 0; a = 0; b = 0; nd = 0; op = 0; disp = 0; dneg = 0; dovf = 0;
      end

      if (go) begin
        if (op == 1) begin res = (a + b) % 10000; rneg = 0; end
        else begin res = (a >= b) ? a - b : b - a; rneg = (b > a); end
        eop = (op == 1) ? 2'b01 : 2'b10;
        alu_result = to_bcd(res); alu_neg = rneg;
        press(k);
        total++;
        if ({op_selected, busy, bcd1, bcd2} !== {eop, 1'b1, to_bcd(a), to_bcd(b)}) begin
          bad++; $display("FAIL rnd_start it=%0d: got op=%b busy=%b %h %h want %b 1 %h %h", it,
                          op_selected, busy, bcd1, bcd2, eop, to_bcd(a), to_bcd(b));
        end
        stable = 1; cyc = 0;
        while (cyc < 20) begin
          if (op_selected !== eop || bcd1 !== to_bcd(a) || bcd2 !== to_bcd(b)) stable = 0;
          key_valid = 1'b1;
          key_code  = 4'($urandom_range(0, 9));
          @(negedge clk);
          cyc++;
          if (res_valid) break;
        end
        key_valid = 1'b0;
        total++;
        if (cyc != LAT + 1 || !stable) begin
          bad++; $display("FAIL rnd_wait it=%0d: got cyc=%0d stable=%0d want %0d 1", it, cyc,
                          stable, LAT + 1);
        end
        disp = res; dneg = rneg; dovf = (op == 1) && (res < a); ph = 2;
      end else begin
        press(k);
      end
      exp_v = {to_bcd(a), to_bcd(b), to_bcd(disp), dneg, dovf, 2'b00, 1'b0};
      got_v = {bcd1, bcd2, disp_bcd, disp_neg, disp_ovf, op_selected, busy};
      total++;
      if (got_v !== exp_v) begin
        bad++; $display("FAIL rnd_state it=%0d key=%h: got %h want %h", it, k, got_v, exp_v);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_chain();
    test_sub_neg();
    test_digit_limit_ovf();
    test_clr_in_wait();
    test_async_clear();
    test_random(300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
